// File: rtl/gate_test_sequencer.sv
// Stimulus/response engine for N-input basic gates: sweeps every input vector
// into a gate under test, compares its output to a golden model, reports results.
module gate_test_sequencer #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             dut_out,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             bad_mode,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail
);

  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned EW  = WIDTH + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] stim_q,       stim_d;
  logic [HCW-1:0]   hold_q,       hold_d;
  logic [2:0]       mode_q,       mode_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             pass_q,       pass_d;
  logic             bad_mode_q,   bad_mode_d;
  logic [EW-1:0]    err_count_q,  err_count_d;
  logic [WIDTH-1:0] first_fail_q, first_fail_d;

  logic sample_c;
  logic last_vec_c;
  logic mismatch_c;

  // Expected gate output for the latched function; illegal codes never reach RUN.
  function automatic logic golden(input logic [2:0] m, input logic [WIDTH-1:0] v);
    logic r;
    r = 1'b0;
    case (m)
      3'b000:  r = &v;
      3'b001:  r = |v;
      3'b010:  r = ~(&v);
      3'b011:  r = ~(|v);
      3'b100:  r = ^v;
      3'b101:  r = ~(^v);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign sample_c   = (hold_q == HOLD_LAST);
  assign last_vec_c = &stim_q;
  assign mismatch_c = (dut_out != golden(mode_q, stim_q));

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    hold_d       = hold_q;
    mode_d       = mode_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    bad_mode_d   = bad_mode_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d       = mode;
          err_count_d  = '0;
          first_fail_d = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          hold_d       = '0;
          stim_d       = '0;
          // 110/111 have no golden function: report immediately without a sweep.
          if (mode[2] && mode[1]) begin
            state_d    = S_DONE;
            bad_mode_d = 1'b1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
          end else begin
            state_d    = S_RUN;
            bad_mode_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
      end

      S_RUN: begin
        hold_d = hold_q + 1'b1;
        if (sample_c) begin
          if (mismatch_c) begin
            err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0) begin
              first_fail_d = stim_q;
            end
          end
          hold_d = '0;
          if (last_vec_c) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end else begin
            stim_d = stim_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stim_q       <= '0;
      hold_q       <= '0;
      mode_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      bad_mode_q   <= 1'b0;
      err_count_q  <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      hold_q       <= hold_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      bad_mode_q   <= bad_mode_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign bad_mode   = bad_mode_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Self-checking stimulus and response engine for N-input basic gates. It replaces hand-written toggle stimulus in gate benches.
- Sweeps all 2^WIDTH input vectors into a gate under test (GUT) and holds each vector for a programmable number of cycles.
- Samples the GUT output and compares it against a golden model of the selected gate function.
- Reports error count, first failing vector and pass/fail. Sits between a bench top (or an on-chip BIST wrapper) and any basic-gate primitive.

Parameters:
- WIDTH, 2, number of GUT inputs; legal range 1..8.
- HOLD_CYCLES, 5, cycles each vector is held before the GUT output is sampled; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- mode  input  3  gate function: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR; 110/111 illegal.
- dut_out  input  1  GUT output.
- stim  output  WIDTH  vector driven to the GUT inputs.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep end until the next accepted start or rst.
- pass  output  1  valid when done=1; 1 iff err_count==0 and bad_mode==0.
- bad_mode  output  1  the latched mode was illegal.
- err_count  output  WIDTH+1  number of mismatching vectors.
- first_fail  output  WIDTH  stim value at the first mismatch; 0 if none.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset (rst=1 at a clock edge, in any state, including mid-sweep):
  - state=IDLE.
  - stim=0, busy=0, done=0, pass=0, bad_mode=0, err_count=0, first_fail=0.
  - Internal hold counter=0.
  - rst has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Latch mode into mode_q.
  - Clear err_count, first_fail, done, pass and the hold counter.
  - stim=0.
  - If mode is 110/111: go to DONE next cycle with bad_mode=1, pass=0, done=1; no vectors are driven.
  - Otherwise: bad_mode=0, busy=1, go to RUN.
- RUN:
  - Hold counter increments every cycle.
  - Sample point: when hold counter==HOLD_CYCLES-1, compare dut_out with expected(mode_q, stim).
    - Mismatch: err_count+1; if err_count was 0, first_fail=stim.
    - If stim==all-ones: go to DONE (busy=0, done=1, pass=(final err_count==0)).
    - Else: stim+1 and hold counter=0.
  - start is ignored in RUN; mode changes in RUN are ignored (mode_q is used).
- Golden model:
  - AND: reduction-AND of stim; OR: reduction-OR.
  - NAND/NOR: inverses of AND/OR.
  - XOR: odd parity; XNOR: its inverse.
- Timing:
  - The first vector appears on stim the cycle after start is accepted.
  - Sweep length is exactly 2^WIDTH*HOLD_CYCLES cycles of busy=1.
  - done rises on the cycle after the last sample.
- DONE: stim holds its last value (all-ones after a legal sweep, 0 after bad mode). All results stay stable until start or rst.
- Width rules:
  - err_count width WIDTH+1 holds the maximum 2^WIDTH without overflow, so no saturation logic is needed.
  - Hold counter width is clog2(HOLD_CYCLES), minimum 1.
- Boundaries:
  - WIDTH=1 sweeps vectors 0 then 1.
  - HOLD_CYCLES=1 samples every cycle, with stim advancing each cycle.
  - start coincident with the final sample in RUN is ignored.

Test Plan:
- WIDTH=2, HOLD_CYCLES=5, mode=000, GUT=correct AND: start -> busy high 20 cycles; stim sequence 0,1,2,3 each held 5 cycles; done=1, pass=1, err_count=0.
- Same setup, GUT=OR gate wired in while mode=000 (AND): mismatches at stim 1 and 2 -> err_count=2, first_fail=1, pass=0.
- WIDTH=3, HOLD_CYCLES=1, mode=100, GUT stuck at 0 -> mismatches on vectors 1,2,4,7 -> err_count=4, first_fail=1; busy high 8 cycles.
- mode=111, start -> next cycle done=1, bad_mode=1, pass=0, busy never asserted, stim=0.
- rst=1 asserted at cycle 7 of a WIDTH=2 sweep -> next edge: all outputs 0, state IDLE; a new start yields a full 20-cycle sweep with err_count counted from 0.
- start held high throughout RUN, mode toggled mid-sweep -> sweep not restarted, results reflect the originally latched mode; after done, a single start pulse restarts with stim=0.
